// File: rtl/accel_mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accel_mem_arbiter_pkg : shared types and index helpers            |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package accel_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  // Requester index width; a single requester still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_mem_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at i_ptr     |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module rr_arbiter
  import accel_mem_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int c_idx_w = idx_width(N)
) (
  input  logic [N-1:0]       i_req,
  input  logic [c_idx_w-1:0] i_ptr,
  output logic [c_idx_w-1:0] o_gnt_idx,
  output logic               o_gnt_valid
);

  logic [c_idx_w-1:0] w_idx;

  always_comb begin
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_idx       = '0;
    // Scan farthest offset first so the requester nearest to i_ptr overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = c_idx_w'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_gnt_idx   = w_idx;
        o_gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | accel_mem_arbiter : shares one CPU memory port among accelerators |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module accel_mem_arbiter
  import accel_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 512,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          i_req_wr_en,
  input  logic [NUM_REQ-1:0]          i_req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_wr_data,
  output logic [NUM_REQ-1:0]          o_req_wr_done,
  output logic [NUM_REQ-1:0]          o_req_rd_valid,
  output logic [NUM_REQ-1:0]          o_req_err,
  output logic [RD_W-1:0]             o_req_rd_data,
  output logic                        o_mem_wr_en,
  output logic                        o_mem_rd_en,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wr_data,
  input  logic                        i_mem_wr_done,
  input  logic                        i_mem_rd_valid,
  input  logic [RD_W-1:0]             i_mem_rd_data,
  output logic                        o_busy
);

  localparam int c_idx_w = idx_width(NUM_REQ);
  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_sat  = {c_tmo_w{1'b1}};

  arb_state_t          r_state;
  mem_op_t             r_op;
  logic [c_idx_w-1:0]  r_owner;
  logic [c_idx_w-1:0]  r_rr_ptr;
  logic [c_tmo_w-1:0]  r_tmo_cnt;

  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  w_last_done;
  logic [NUM_REQ-1:0]  w_wr_pend;
  logic [NUM_REQ-1:0]  w_rd_pend;
  logic [NUM_REQ-1:0]  w_pend;
  logic [c_idx_w-1:0]  w_gnt_idx;
  logic                w_gnt_valid;
  logic                w_gnt_is_wr;
  logic                w_resp_match;
  logic                w_tmo_hit;
  logic [c_idx_w-1:0]  w_owner_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = i_req_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi] = i_req_wr_data[gi*DATA_W +: DATA_W];
  end

  // In the pulse cycle the finished owner still holds its level request; mask
  // only the op that just completed so a held wr+rd pair moves on to the read.
  assign w_last_done = o_req_wr_done | o_req_rd_valid | o_req_err;
  assign w_wr_pend   = i_req_wr_en & ~(w_last_done & {NUM_REQ{r_op == OP_WR}});
  assign w_rd_pend   = i_req_rd_en & ~(w_last_done & {NUM_REQ{r_op == OP_RD}});
  assign w_pend      = w_wr_pend | w_rd_pend;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .i_req       (w_pend),
    .i_ptr       (r_rr_ptr),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_gnt_is_wr  = w_wr_pend[w_gnt_idx];
  assign w_resp_match = (r_op == OP_WR) ? i_mem_wr_done : i_mem_rd_valid;
  assign w_tmo_hit    = (r_tmo_cnt == c_tmo_last);
  assign w_owner_next = c_idx_w'(wrap_inc(int'(r_owner), NUM_REQ));
  assign o_busy       = (r_state != ARB_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ARB_IDLE;
      r_op           <= OP_RD;
      r_owner        <= '0;
      r_rr_ptr       <= '0;
      r_tmo_cnt      <= '0;
      o_req_wr_done  <= '0;
      o_req_rd_valid <= '0;
      o_req_err      <= '0;
      o_req_rd_data  <= '0;
      o_mem_wr_en    <= 1'b0;
      o_mem_rd_en    <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wr_data  <= '0;
    end else begin
      o_req_wr_done  <= '0;
      o_req_rd_valid <= '0;
      o_req_err      <= '0;
      o_mem_wr_en    <= 1'b0;
      o_mem_rd_en    <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_valid) begin
            r_owner       <= w_gnt_idx;
            r_op          <= w_gnt_is_wr ? OP_WR : OP_RD;
            o_mem_addr    <= w_addr_arr[w_gnt_idx];
            o_mem_wr_data <= w_data_arr[w_gnt_idx];
            o_mem_wr_en   <= w_gnt_is_wr;
            o_mem_rd_en   <= ~w_gnt_is_wr;
            r_state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE, ARB_WAIT: begin
          if (w_resp_match) begin
            if (r_op == OP_WR) begin
              o_req_wr_done[r_owner] <= 1'b1;
            end else begin
              o_req_rd_valid[r_owner] <= 1'b1;
              o_req_rd_data           <= i_mem_rd_data;
            end
            r_rr_ptr <= w_owner_next;
            r_state  <= ARB_IDLE;
          end else if ((r_state == ARB_WAIT) && w_tmo_hit) begin
            o_req_err[r_owner] <= 1'b1;
            r_rr_ptr           <= w_owner_next;
            r_state            <= ARB_IDLE;
          end else begin
            r_state <= ARB_WAIT;
            if (r_state == ARB_ISSUE) begin
              r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_tmo_sat) begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_accel_mem_arbiter : random engines/memory vs transaction model |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_accel_mem_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int RD_W    = 512;
  localparam int TIMEOUT = 8;
  localparam int N_CYC   = 4000;
  localparam int RST_AT  = 2000;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        i_req_wr_en = '0;
  logic [NUM_REQ-1:0]        i_req_rd_en = '0;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] i_req_wr_data = '0;
  logic [NUM_REQ-1:0]        o_req_wr_done;
  logic [NUM_REQ-1:0]        o_req_rd_valid;
  logic [NUM_REQ-1:0]        o_req_err;
  logic [RD_W-1:0]           o_req_rd_data;
  logic                      o_mem_wr_en;
  logic                      o_mem_rd_en;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wr_data;
  logic                      i_mem_wr_done = 1'b0;
  logic                      i_mem_rd_valid = 1'b0;
  logic [RD_W-1:0]           i_mem_rd_data = '0;
  logic                      o_busy;

  accel_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_W    (RD_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_wr_en    (i_req_wr_en),
    .i_req_rd_en    (i_req_rd_en),
    .i_req_addr     (i_req_addr),
    .i_req_wr_data  (i_req_wr_data),
    .o_req_wr_done  (o_req_wr_done),
    .o_req_rd_valid (o_req_rd_valid),
    .o_req_err      (o_req_err),
    .o_req_rd_data  (o_req_rd_data),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wr_data  (o_mem_wr_data),
    .i_mem_wr_done  (i_mem_wr_done),
    .i_mem_rd_valid (i_mem_rd_valid),
    .i_mem_rd_data  (i_mem_rd_data),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [RD_W-1:0] got, input logic [RD_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Engine side: level requests held until the engine sees its pulse.
  logic [NUM_REQ-1:0] want_wr = '0;
  logic [NUM_REQ-1:0] want_rd = '0;
  logic [ADDR_W-1:0]  eng_addr [NUM_REQ];
  logic [DATA_W-1:0]  eng_data [NUM_REQ];

  // Transaction-level expectation for the current cycle.
  int                 cyc = 0;
  int                 m_ptr = 0;
  bit                 m_active = 1'b0;
  int                 m_owner = 0;
  bit                 m_is_wr = 1'b0;
  bit                 m_silent = 1'b0;
  int                 m_strobe = 0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [DATA_W-1:0]  m_data = '0;
  logic [NUM_REQ-1:0] e_wd = '0, e_rv = '0, e_er = '0;
  logic [NUM_REQ-1:0] p_wd = '0, p_rv = '0, p_er = '0;
  bit                 e_last_wr = 1'b0, p_last_wr = 1'b0;
  logic [RD_W-1:0]    e_rdata = '0;
  bit                 rst_done = 1'b0;
  bit                 force_late = 1'b0;

  task automatic drive_engines();
    i_req_wr_en = want_wr;
    i_req_rd_en = want_rd;
    for (int i = 0; i < NUM_REQ; i++) begin
      i_req_addr[i*ADDR_W +: ADDR_W]    = eng_addr[i];
      i_req_wr_data[i*DATA_W +: DATA_W] = eng_data[i];
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"},  o_busy, 0);
    chk({pfx, "_wr_en"}, o_mem_wr_en, 0);
    chk({pfx, "_rd_en"}, o_mem_rd_en, 0);
    chk({pfx, "_pulses"}, {o_req_wr_done, o_req_rd_valid, o_req_err}, 0);
    chk({pfx, "_addr"},  o_mem_addr, 0);
    chk({pfx, "_wdata"}, o_mem_wr_data, 0);
    chk({pfx, "_rdata"}, o_req_rd_data, 0);
  endtask

  initial begin
    logic [NUM_REQ-1:0] mask, pend_wr, pend_rd, n_wd, n_rv, n_er;
    logic [RD_W-1:0]    n_rdata;
    bit                 resp_match, pulse_now, n_active, n_last_wr;
    int                 r, idx;

    for (int i = 0; i < NUM_REQ; i++) begin
      eng_addr[i] = '0;
      eng_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;

    for (int it = 0; it < N_CYC; it++) begin
      @(posedge clk);
      #1;
      chk("busy",      o_busy, m_active);
      chk("mem_wr_en", o_mem_wr_en, m_active && (cyc == m_strobe) && m_is_wr);
      chk("mem_rd_en", o_mem_rd_en, m_active && (cyc == m_strobe) && !m_is_wr);
      if (m_active) begin
        chk("mem_addr",  o_mem_addr, m_addr);
        chk("mem_wdata", o_mem_wr_data, m_data);
      end
      chk("wr_done",  o_req_wr_done, e_wd);
      chk("rd_valid", o_req_rd_valid, e_rv);
      chk("err",      o_req_err, e_er);
      chk("rd_data",  o_req_rd_data, e_rdata);

      // Asynchronous reset once, in the middle of a transaction's wait phase.
      if (!rst_done && cyc >= RST_AT && m_active && cyc > m_strobe) begin
        rst_done = 1'b1;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        m_active = 1'b0;
        m_ptr    = 0;
        e_wd = '0; e_rv = '0; e_er = '0;
        p_wd = '0; p_rv = '0; p_er = '0;
        e_rdata  = '0;
        force_late = 1'b1;
      end

      // Engines react one cycle after their pulse.
      want_wr &= ~p_wd;
      want_rd &= ~p_rv;
      if (p_last_wr) want_wr &= ~p_er;
      else           want_rd &= ~p_er;
      p_wd = e_wd; p_rv = e_rv; p_er = e_er; p_last_wr = e_last_wr;

      pulse_now = |(e_wd | e_rv | e_er);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_active && i == m_owner) begin
          if ($urandom_range(0, 99) < 3) begin
            if (m_is_wr) want_wr[i] = 1'b0;
            else         want_rd[i] = 1'b0;
          end
        end else if (!want_wr[i] && !want_rd[i] && !(i == m_owner && pulse_now)
                     && $urandom_range(0, 99) < 30) begin
          eng_addr[i] = ADDR_W'($urandom());
          eng_data[i] = $urandom();
          r = $urandom_range(0, 99);
          want_wr[i] = (r < 40) || (r >= 80);
          want_rd[i] = (r >= 40);
        end
      end
      drive_engines();

      // Memory side for this cycle.
      for (int k = 0; k < RD_W / 32; k++) i_mem_rd_data[k*32 +: 32] = $urandom();
      i_mem_wr_done  = 1'b0;
      i_mem_rd_valid = 1'b0;
      resp_match     = 1'b0;
      if (m_active) begin
        r = $urandom_range(0, 99);
        if (!m_silent && r < 30) begin
          resp_match     = 1'b1;
          i_mem_wr_done  = m_is_wr;
          i_mem_rd_valid = !m_is_wr;
        end else if (r < 45) begin
          i_mem_wr_done  = !m_is_wr;
          i_mem_rd_valid = m_is_wr;
        end
      end else if (force_late || $urandom_range(0, 99) < 10) begin
        i_mem_wr_done  = force_late | $urandom_range(0, 1) == 1;
        i_mem_rd_valid = force_late | $urandom_range(0, 1) == 1;
      end
      force_late = 1'b0;

      // Predict the next cycle from the rules of the port.
      n_wd = '0; n_rv = '0; n_er = '0;
      n_rdata   = e_rdata;
      n_active  = m_active;
      n_last_wr = e_last_wr;
      if (m_active) begin
        if (resp_match) begin
          if (m_is_wr) n_wd[m_owner] = 1'b1;
          else begin
            n_rv[m_owner] = 1'b1;
            n_rdata = i_mem_rd_data;
          end
        end else if (cyc == m_strobe + TIMEOUT) begin
          n_er[m_owner] = 1'b1;
        end
        if (resp_match || cyc == m_strobe + TIMEOUT) begin
          m_ptr     = (m_owner + 1) % NUM_REQ;
          n_active  = 1'b0;
          n_last_wr = m_is_wr;
        end
      end else begin
        mask    = e_wd | e_rv | e_er;
        pend_wr = want_wr & ~(e_last_wr ? mask : '0);
        pend_rd = want_rd & ~(e_last_wr ? '0 : mask);
        idx = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (idx < 0 && (pend_wr[(m_ptr + k) % NUM_REQ] || pend_rd[(m_ptr + k) % NUM_REQ]))
            idx = (m_ptr + k) % NUM_REQ;
        end
        if (idx >= 0) begin
          m_owner  = idx;
          m_is_wr  = pend_wr[idx];
          m_addr   = eng_addr[idx];
          m_data   = eng_data[idx];
          m_strobe = cyc + 1;
          m_silent = ($urandom_range(0, 99) < 15);
          n_active = 1'b1;
        end
      end
      m_active  = n_active;
      e_wd = n_wd; e_rv = n_rv; e_er = n_er;
      e_last_wr = n_last_wr;
      e_rdata   = n_rdata;
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
